// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: CPU-side transfer controller for an asynchronous SRAM plus memory-mapped switch/hex IO.
//
// Ports:
//   Clk, Reset          clock (rising edge) and asynchronous active-low reset
//   Req, Wr, Addr, Wdata CPU request, sampled only while IDLE
//   Rdata, Ready, Busy  registered read result, one-cycle completion pulse, not-IDLE flag
//   Switches, Hex       switch input read and hex display written at IO_ADDR (all ones)
//   Mem_CE/UB/LB/OE/WE  active-low SRAM strobes, active only in ACCESS
//   SRAM_ADDR           address latched at accept
//   Data_to_SRAM, Data_from_SRAM, Drive_EN  SRAM data bus halves and tristate enable
//   LED                 only with MEM_IO_LED_EN: 12-bit register written at IO_ADDR-1
module mem_io_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int HEX_DIGITS = 4,
    parameter int WAIT_CYC   = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Req,
    input  logic                    Wr,
    input  logic [ADDR_W-1:0]       Addr,
    input  logic [DATA_W-1:0]       Wdata,
    output logic [DATA_W-1:0]       Rdata,
    output logic                    Ready,
    output logic                    Busy,
    input  logic [DATA_W-1:0]       Switches,
    output logic [4*HEX_DIGITS-1:0] Hex,
    output logic                    Mem_CE,
    output logic                    Mem_UB,
    output logic                    Mem_LB,
    output logic                    Mem_OE,
    output logic                    Mem_WE,
    output logic [ADDR_W-1:0]       SRAM_ADDR,
    output logic [DATA_W-1:0]       Data_to_SRAM,
    input  logic [DATA_W-1:0]       Data_from_SRAM,
    output logic                    Drive_EN
`ifdef MEM_IO_LED_EN
    ,
    output logic [11:0]             LED
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [ADDR_W-1:0] IO_ADDR = '1;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic io_hit;
    logic accept;
`ifdef MEM_IO_LED_EN
    localparam logic [ADDR_W-1:0] LED_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
    assign io_hit = (Addr == IO_ADDR) || (Addr == LED_ADDR);
`else
    assign io_hit = Addr == IO_ADDR;
`endif
    assign accept       = (state == IDLE) && Req;
    assign Data_to_SRAM = wdata_q;
    always_comb begin
        state_nx = state;
        Mem_CE   = 1'b1;
        Mem_UB   = 1'b1;
        Mem_LB   = 1'b1;
        Mem_OE   = 1'b1;
        Mem_WE   = 1'b1;
        Drive_EN = 1'b0;
        Ready    = 1'b0;
        Busy     = state != IDLE;
        unique case (state)
            IDLE:    state_nx = Req ? (io_hit ? DONE : ACCESS) : IDLE;
            ACCESS: begin
                Mem_CE   = 1'b0;
                Mem_UB   = 1'b0;
                Mem_LB   = 1'b0;
                Mem_OE   = wr_q;
                Mem_WE   = !wr_q;
                Drive_EN = wr_q;
                state_nx = (cnt == '0) ? DONE : ACCESS;
            end
            DONE: begin
                Ready    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // IO accesses complete on the accepting edge itself, so the register
    // updates happen there rather than in a dedicated state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            SRAM_ADDR <= '0;
            Rdata     <= '0;
            Hex       <= '0;
`ifdef MEM_IO_LED_EN
            LED       <= '0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                SRAM_ADDR <= Addr;
                wr_q      <= Wr;
                wdata_q   <= Wdata;
                cnt       <= 4'(WAIT_CYC - 1);
                if (Addr == IO_ADDR) begin
                    if (Wr) Hex <= Wdata[4*HEX_DIGITS-1:0];
                    else    Rdata <= Switches;
                end
`ifdef MEM_IO_LED_EN
                else if (Addr == LED_ADDR) begin
                    if (Wr) LED <= Wdata[11:0];
                    else    Rdata <= '0;
                end
`endif
            end else if (state == ACCESS) begin
                cnt <= (cnt == '0) ? cnt : cnt - 4'd1;
                if (cnt == '0 && !wr_q) Rdata <= Data_from_SRAM;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: scoreboard bench for mem_io_ctrl SRAM and IO transfers
module tb_mem_io_ctrl;
    localparam int WAIT_CYC = 2;
    localparam int SRAM_LAT = WAIT_CYC + 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0, wr = 1'b0;
    logic [19:0] addr = '0;
    logic [15:0] wdata = '0, rdata, switches = '0, hex, data_to_sram, data_from_sram = '0;
    logic ready, busy, mem_ce, mem_ub, mem_lb, mem_oe, mem_we, drive_en;
    logic [19:0] sram_addr;
`ifdef MEM_IO_LED_EN
    logic [11:0] led;
`endif
    typedef struct {logic [15:0] rdata; int cyc;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0;
    logic [15:0] model_rdata = '0;

    mem_io_ctrl #(.DATA_W(16), .ADDR_W(20), .HEX_DIGITS(4), .WAIT_CYC(WAIT_CYC)) dut (
        .Clk(clk), .Reset(rst_n), .Req(req), .Wr(wr), .Addr(addr), .Wdata(wdata),
        .Rdata(rdata), .Ready(ready), .Busy(busy), .Switches(switches), .Hex(hex),
        .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb), .Mem_OE(mem_oe), .Mem_WE(mem_we),
        .SRAM_ADDR(sram_addr), .Data_to_SRAM(data_to_sram), .Data_from_SRAM(data_from_sram),
        .Drive_EN(drive_en)
`ifdef MEM_IO_LED_EN
        , .LED(led)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", 32'(rdata), 32'(e.rdata));
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic xfer(input logic w, input logic [19:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int lat);
        int ce_n = 0, we_n = 0, oe_n = 0, de_n = 0, n = 0;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = wd;
        if (!w) model_rdata = rd;
        sb.push_back('{model_rdata, cyc + lat});
        @(negedge clk);
        req = 1'b0;
        check("sram_addr", 32'(sram_addr), 32'(a));
        while (!ready && n < 20) begin
            ce_n += int'(!mem_ce); we_n += int'(!mem_we); oe_n += int'(!mem_oe); de_n += int'(drive_en);
            if (!mem_we) check("data_to_sram", 32'(data_to_sram), 32'(wd));
            n++;
            @(negedge clk);
        end
        check("timeout", 32'(n < 20), 32'd1);
        check("ce_cycles", 32'(ce_n), 32'(lat > 1 ? WAIT_CYC : 0));
        check("we_cycles", 32'(we_n), 32'((lat > 1 && w) ? WAIT_CYC : 0));
        check("oe_cycles", 32'(oe_n), 32'((lat > 1 && !w) ? WAIT_CYC : 0));
        check("drive_en_cycles", 32'(de_n), 32'((lat > 1 && w) ? WAIT_CYC : 0));
        @(negedge clk);
        check("idle_strobes", 32'({mem_ce, mem_ub, mem_lb, mem_oe, mem_we, drive_en, busy}), 32'h7C);
    endtask

    initial begin
        int c;
        int n;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({ready, busy, drive_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we}), 32'h1F);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_hex", 32'(hex), 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        rst_n = 1'b1;
        xfer(1'b1, 20'h00010, 16'hBEEF, 16'h0, SRAM_LAT);
        data_from_sram = 16'hBEEF;
        xfer(1'b0, 20'h00010, 16'h0, 16'hBEEF, SRAM_LAT);
        xfer(1'b1, 20'hFFFFF, 16'h1234, 16'h0, 1);
        check("hex", 32'(hex), 32'h1234);
        switches = 16'h00A5;
        xfer(1'b0, 20'hFFFFF, 16'h0, 16'h00A5, 1);
        check("hex_hold", 32'(hex), 32'h1234);
`ifdef MEM_IO_LED_EN
        xfer(1'b1, 20'hFFFFE, 16'h0FAB, 16'h0, 1);
        check("led", 32'(led), 32'hFAB);
        xfer(1'b0, 20'hFFFFE, 16'h0, 16'h0, 1);
`else
        xfer(1'b1, 20'hFFFFE, 16'h0FAB, 16'h0, SRAM_LAT);
`endif
        data_from_sram = 16'h1111;
        @(negedge clk);
        c = cyc;
        req = 1'b1; wr = 1'b0; addr = 20'h00040;
        sb.push_back('{16'h1111, c + 3});
        sb.push_back('{16'h2222, c + 7});
        repeat (3) @(negedge clk);
        data_from_sram = 16'h2222;
        @(negedge clk);
        check("idle_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req = 1'b0;
        check("second_accept_busy", 32'(busy), 32'd1);
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
        check("b2b_drain", 32'(sb.size()), 32'd0);
        model_rdata = 16'h2222;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 20'h00020; wdata = 16'hCAFE;
        @(negedge clk);
        req = 1'b0;
        check("abort_we_active", 32'({mem_we, drive_en}), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_immediate", 32'({mem_ce, mem_ub, mem_lb, mem_oe, mem_we, drive_en, busy, ready}), 32'hF8);
        check("abort_rdata", 32'(rdata), 32'h0);
        check("abort_hex", 32'(hex), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_completion", 32'({busy, mem_we}), 32'h1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
